// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
//
// Parametrised asynchronous serial receiver for the debug-unit command path.
// The rxd line is synchronised, sampled with a 16x oversample clock and each
// bit is decided by a 3-sample majority vote around mid-bit (os = 7, 8, 9).
// A start bit whose majority reads 1 is treated as a glitch and dropped.
// Received characters are offered on a valid/ready handshake together with
// framing and parity flags; a frame that completes while the previous
// character is still held is dropped and reported with a one-cycle ovr_err.
//
// Parameters
//   CLK_DIV   clk cycles per oversample tick (>= 2)
//   DATA_BITS data bits per frame, LSB first on the line (5..9)
//   PARITY    0 none, 1 odd, 2 even
//   STOP_BITS 1 or 2
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   rxd      in   asynchronous serial line, idle high
//   rdy_rx   in   consumer ready
//   d_rx     out  received character, first-received bit in d_rx[0]
//   vld_rx   out  d_rx / frm_err / par_err valid, held until transfer
//   frm_err  out  a stop-bit majority was 0 for the held character
//   par_err  out  parity mismatch for the held character
//   ovr_err  out  one-cycle pulse: completed frame dropped (vld_rx still 1)
//   busy     out  receiver FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_param #(
  parameter int CLK_DIV   = 54,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rdy_rx,
  output logic [DATA_BITS-1:0] d_rx,
  output logic                 vld_rx,
  output logic                 frm_err,
  output logic                 par_err,
  output logic                 ovr_err,
  output logic                 busy
);

  localparam int              TW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0]   TICK_MAX   = TW'(CLK_DIV - 1);
  localparam logic [3:0]      BIT_LAST   = 4'(DATA_BITS - 1);
  localparam bit              HAS_PARITY = (PARITY != 0);
  localparam bit              TWO_STOP   = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Majority of three samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

  // Parity error for the received data word and the received parity bit.
  function automatic logic parity_err(input logic [DATA_BITS-1:0] data,
                                      input logic                 pbit);
    logic sum;
    sum = (^data) ^ pbit;
    if (PARITY == 1) begin
      parity_err = ~sum;
    end else if (PARITY == 2) begin
      parity_err = sum;
    end else begin
      parity_err = 1'b0;
    end
  endfunction

  // Synchroniser and edge history
  logic                 r_sync1;
  logic                 r_rxd_s;
  logic                 r_rxd_prev;

  // Timing
  logic [TW-1:0]        r_tick_cnt;
  logic [3:0]           r_os;
  logic                 r_s7;
  logic                 r_s8;

  // Frame assembly
  state_t               r_state;
  state_t               w_next_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [3:0]           r_bit_cnt;
  logic                 r_stop_cnt;
  logic                 r_par_acc;
  logic                 r_frm_acc;
  logic                 r_done;

  // Output holding registers
  logic [DATA_BITS-1:0] r_d;
  logic                 r_vld;
  logic                 r_frm;
  logic                 r_par;
  logic                 r_ovr;
  logic                 r_busy;

  // Combinational helpers
  logic                 w_tick;
  logic                 w_mid;
  logic                 w_end;
  logic                 w_maj;
  logic                 w_start_edge;
  logic                 w_last_stop;
  logic                 w_xfer;
  logic                 w_load;
  logic                 w_shift_en;
  logic                 w_bit_adv;
  logic                 w_par_chk;
  logic                 w_stop_chk;
  logic                 w_stop_adv;
  logic                 w_frame_end;

  assign w_tick       = (r_tick_cnt == TICK_MAX);
  assign w_mid        = w_tick && (r_os == 4'd9);
  assign w_end        = w_tick && (r_os == 4'd15);
  // Third vote is the live synchronised line in the os=9 tick cycle.
  assign w_maj        = maj3(r_s7, r_s8, r_rxd_s);
  // A falling edge is only honoured from IDLE; a line that is already low
  // (break) never produces a new edge until it has returned high.
  assign w_start_edge = (r_state == S_IDLE) && !r_rxd_s && r_rxd_prev;
  assign w_last_stop  = TWO_STOP ? r_stop_cnt : 1'b1;
  assign w_xfer       = r_vld && rdy_rx;
  assign w_load       = !r_vld || w_xfer;

  // Two-flop synchroniser plus previous-value flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_rxd_s    <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_sync1    <= rxd;
      r_rxd_s    <= r_sync1;
      r_rxd_prev <= r_rxd_s;
    end
  end

  // Oversample tick divider; realigned to the start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_start_edge || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // Oversample position within the current bit, held at 0 while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_os <= 4'd0;
    end else if (r_state == S_IDLE) begin
      r_os <= 4'd0;
    end else if (w_tick) begin
      r_os <= (r_os == 4'd15) ? 4'd0 : r_os + 4'd1;
    end
  end

  // First two majority samples of each bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s7 <= 1'b1;
      r_s8 <= 1'b1;
    end else begin
      if (w_tick && (r_os == 4'd7)) r_s7 <= r_rxd_s;
      if (w_tick && (r_os == 4'd8)) r_s8 <= r_rxd_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) w_next_state = S_START;
        else              w_next_state = S_IDLE;
      end
      S_START: begin
        if (w_mid && w_maj) w_next_state = S_IDLE;
        else if (w_end)     w_next_state = S_DATA;
        else                w_next_state = S_START;
      end
      S_DATA: begin
        if (w_end && (r_bit_cnt == BIT_LAST)) begin
          w_next_state = HAS_PARITY ? S_PARITY : S_STOP;
        end else begin
          w_next_state = S_DATA;
        end
      end
      S_PARITY: begin
        if (w_end) w_next_state = S_STOP;
        else       w_next_state = S_PARITY;
      end
      S_STOP: begin
        // Finish mid-bit so a start edge right after the stop bit is seen.
        if (w_mid && w_last_stop) w_next_state = S_IDLE;
        else                      w_next_state = S_STOP;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM output decode: per-state strobes for the datapath.
  always_comb begin
    w_shift_en  = 1'b0;
    w_bit_adv   = 1'b0;
    w_par_chk   = 1'b0;
    w_stop_chk  = 1'b0;
    w_stop_adv  = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE:   w_shift_en = 1'b0;
      S_START:  w_shift_en = 1'b0;
      S_DATA: begin
        w_shift_en = w_mid;
        w_bit_adv  = w_end;
      end
      S_PARITY: w_par_chk = w_mid;
      S_STOP: begin
        w_stop_chk  = w_mid;
        w_stop_adv  = w_end;
        w_frame_end = w_mid && w_last_stop;
      end
      default:  w_shift_en = 1'b0;
    endcase
  end

  // Frame assembly: data shift register, bit/stop counters, error accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_bit_cnt  <= 4'd0;
      r_stop_cnt <= 1'b0;
      r_par_acc  <= 1'b0;
      r_frm_acc  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_frame_end;
      if (w_start_edge) begin
        r_shift    <= '0;
        r_bit_cnt  <= 4'd0;
        r_stop_cnt <= 1'b0;
        r_par_acc  <= 1'b0;
        r_frm_acc  <= 1'b0;
      end else begin
        // LSB arrives first, so new bits enter at the MSB and move down.
        if (w_shift_en) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
        if (w_bit_adv) begin
          r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? 4'd0 : r_bit_cnt + 4'd1;
        end
        if (w_par_chk)  r_par_acc  <= parity_err(r_shift, w_maj);
        if (w_stop_chk) r_frm_acc  <= r_frm_acc | ~w_maj;
        if (w_stop_adv) r_stop_cnt <= 1'b1;
      end
    end
  end

  // Output holding registers and handshake; overrun keeps the old character.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d    <= '0;
      r_vld  <= 1'b0;
      r_frm  <= 1'b0;
      r_par  <= 1'b0;
      r_ovr  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_ovr  <= 1'b0;
      r_busy <= (w_next_state != S_IDLE);
      if (r_done) begin
        if (w_load) begin
          r_d   <= r_shift;
          r_frm <= r_frm_acc;
          r_par <= r_par_acc;
          r_vld <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (w_xfer) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign d_rx    = r_d;
  assign vld_rx  = r_vld;
  assign frm_err = r_frm;
  assign par_err = r_par;
  assign ovr_err = r_ovr;
  assign busy    = r_busy;

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
//
// Directed bench for uart_rx_param. Four receivers share clk/rst:
//   u0  CLK_DIV=4, 8N1          main function, framing/break, glitch, overrun,
//                               mid-frame reset, exact latency
//   u1  CLK_DIV=4, 8E1          even parity
//   u2  CLK_DIV=4, 5 bits, odd, 2 stop
//   u3  CLK_DIV=5, 9 bits, odd, 2 stop
// Frames are driven on the line bit by bit (16*CLK_DIV clk per bit) and
// every expectation is computed here from the character sent.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rxd_v = 4'hF;
  logic [3:0] rdy_v = 4'hF;
  logic [3:0] vld_v, frm_v, par_v, ovr_v, busy_v;
  logic [7:0] d0, d1;
  logic [4:0] d2;
  logic [8:0] d3;
  logic [8:0] d_v [4];

  assign d_v[0] = {1'b0, d0};
  assign d_v[1] = {1'b0, d1};
  assign d_v[2] = {4'b0, d2};
  assign d_v[3] = d3;

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .rxd(rxd_v[0]), .rdy_rx(rdy_v[0]), .d_rx(d0),
    .vld_rx(vld_v[0]), .frm_err(frm_v[0]), .par_err(par_v[0]),
    .ovr_err(ovr_v[0]), .busy(busy_v[0]));

  uart_rx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .rxd(rxd_v[1]), .rdy_rx(rdy_v[1]), .d_rx(d1),
    .vld_rx(vld_v[1]), .frm_err(frm_v[1]), .par_err(par_v[1]),
    .ovr_err(ovr_v[1]), .busy(busy_v[1]));

  uart_rx_param #(.CLK_DIV(4), .DATA_BITS(5), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .rxd(rxd_v[2]), .rdy_rx(rdy_v[2]), .d_rx(d2),
    .vld_rx(vld_v[2]), .frm_err(frm_v[2]), .par_err(par_v[2]),
    .ovr_err(ovr_v[2]), .busy(busy_v[2]));

  uart_rx_param #(.CLK_DIV(5), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .rxd(rxd_v[3]), .rdy_rx(rdy_v[3]), .d_rx(d3),
    .vld_rx(vld_v[3]), .frm_err(frm_v[3]), .par_err(par_v[3]),
    .ovr_err(ovr_v[3]), .busy(busy_v[3]));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_start = 0;

  int         n_xfer [4] = '{default: 0};
  int         n_ovr  [4] = '{default: 0};
  int         vld_rise_cyc  [4] = '{default: 0};
  int         busy_fall_cyc [4] = '{default: 0};
  logic [8:0] last_d [4] = '{default: 9'h000};
  logic [3:0] last_frm = 4'h0;
  logic [3:0] last_par = 4'h0;
  logic [3:0] prev_vld = 4'h0;
  logic [3:0] prev_busy = 4'h0;

  // Clock cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records transfers, overrun pulses and edge times.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vld_v[i] && rdy_v[i]) begin
        n_xfer[i]   <= n_xfer[i] + 1;
        last_d[i]   <= d_v[i];
        last_frm[i] <= frm_v[i];
        last_par[i] <= par_v[i];
      end
      if (ovr_v[i]) n_ovr[i] <= n_ovr[i] + 1;
      if (vld_v[i] && !prev_vld[i]) vld_rise_cyc[i] <= cyc;
      if (!busy_v[i] && prev_busy[i]) busy_fall_cyc[i] <= cyc;
    end
    prev_vld  <= vld_v;
    prev_busy <= busy_v;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int bit_clk(input int idx);
    return (idx == 3) ? 80 : 64;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input int idx, input logic [15:0] bits, input int n);
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      rxd_v[idx] = bits[b];
      if (b == 0) t_start = cyc;
      repeat (bit_clk(idx) - 1) @(negedge clk);
    end
    @(negedge clk);
    rxd_v[idx] = 1'b1;
  endtask

  // Builds start + data (LSB first) + optional parity + stop bits.
  task automatic send_frame(input int idx, input logic [8:0] data, input int nb,
                            input int pm, input logic pflip, input int ns,
                            input logic stop_v);
    logic [15:0] bits;
    logic        p;
    int          n;
    bits = 16'hFFFF;
    n = 0;
    p = 1'b0;
    bits[n] = 1'b0;
    n++;
    for (int b = 0; b < nb; b++) begin
      bits[n] = data[b];
      p = p ^ data[b];
      n++;
    end
    if (pm == 1) begin
      bits[n] = ~p ^ pflip;
      n++;
    end else if (pm == 2) begin
      bits[n] = p ^ pflip;
      n++;
    end
    for (int s = 0; s < ns; s++) begin
      bits[n] = stop_v;
      n++;
    end
    send_bits(idx, bits, n);
  endtask

  task automatic hold_line(input int idx, input logic val, input int ncyc);
    @(negedge clk);
    rxd_v[idx] = val;
    repeat (ncyc - 1) @(negedge clk);
  endtask

  int         bx, bo, bx2, bx3;
  logic [8:0] rd;

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("rst_d",    32'(d0),        32'h0);
    check_val("rst_vld",  32'(vld_v[0]),  32'h0);
    check_val("rst_frm",  32'(frm_v[0]),  32'h0);
    check_val("rst_par",  32'(par_v[0]),  32'h0);
    check_val("rst_ovr",  32'(ovr_v[0]),  32'h0);
    check_val("rst_busy", 32'(busy_v),    32'h0);
    rst = 1'b0;
    wait_clk(20);

    // 8N1 0xA5 with exact latency: tick k=16*9+10 of the stop bit,
    // vld visible 4 + 4*k cycles after the start bit is driven.
    bx = n_xfer[0];
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1);
    wait_clk(40);
    check_val("a5_xfer",  32'(n_xfer[0] - bx),        32'd1);
    check_val("a5_d",     32'(last_d[0]),             32'h0A5);
    check_val("a5_frm",   32'(last_frm[0]),           32'h0);
    check_val("a5_par",   32'(last_par[0]),           32'h0);
    check_val("a5_ovr",   32'(n_ovr[0]),              32'h0);
    check_val("a5_vld_low", 32'(vld_v[0]),            32'h0);
    check_val("a5_lat",   32'(vld_rise_cyc[0] - t_start),  32'(4 + 4 * (16 * 9 + 10)));
    check_val("a5_busy",  32'(busy_fall_cyc[0] - t_start), 32'(3 + 4 * (16 * 9 + 10)));

    // Even parity: 0x03 has even weight, so the correct parity bit is 0.
    send_frame(1, 9'h003, 8, 2, 1'b1, 1, 1'b1);
    wait_clk(40);
    check_val("ep_bad_d",   32'(last_d[1]),   32'h003);
    check_val("ep_bad_par", 32'(last_par[1]), 32'h1);
    send_frame(1, 9'h003, 8, 2, 1'b0, 1, 1'b1);
    wait_clk(40);
    check_val("ep_ok_par",  32'(last_par[1]), 32'h0);
    check_val("ep_ok_frm",  32'(last_frm[1]), 32'h0);
    check_val("ep_xfer",    32'(n_xfer[1]),   32'd2);

    // Framing error, then break held for three frame times.
    bx = n_xfer[0];
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 1'b0);
    wait_clk(40);
    check_val("fe_d",   32'(last_d[0]),   32'h05A);
    check_val("fe_frm", 32'(last_frm[0]), 32'h1);
    wait_clk(64);
    hold_line(0, 1'b0, 3 * 640);
    rxd_v[0] = 1'b1;
    wait_clk(200);
    check_val("brk_xfer", 32'(n_xfer[0] - bx), 32'd2);
    check_val("brk_d",    32'(last_d[0]),      32'h000);
    check_val("brk_frm",  32'(last_frm[0]),    32'h1);
    check_val("brk_busy", 32'(busy_v[0]),      32'h0);

    // Short glitch: start detected, rejected at the os=9 vote.
    bx = n_xfer[0];
    hold_line(0, 1'b0, 20);
    rxd_v[0] = 1'b1;
    wait_clk(10);
    check_val("gl_busy_hi", 32'(busy_v[0]), 32'h1);
    wait_clk(200);
    check_val("gl_busy_lo", 32'(busy_v[0]),      32'h0);
    check_val("gl_xfer",    32'(n_xfer[0] - bx), 32'd0);
    check_val("gl_vld",     32'(vld_v[0]),       32'h0);

    // Overrun: two frames with the consumer stalled.
    rdy_v[0] = 1'b0;
    bx = n_xfer[0];
    bo = n_ovr[0];
    send_frame(0, 9'h011, 8, 0, 1'b0, 1, 1'b1);
    send_frame(0, 9'h022, 8, 0, 1'b0, 1, 1'b1);
    wait_clk(40);
    check_val("ov_vld",  32'(vld_v[0]),       32'h1);
    check_val("ov_d",    32'(d0),             32'h011);
    check_val("ov_cnt",  32'(n_ovr[0] - bo),  32'd1);
    check_val("ov_xfer", 32'(n_xfer[0] - bx), 32'd0);
    @(posedge clk);
    #1 rdy_v[0] = 1'b1;
    @(posedge clk);
    #1 check_val("ov_vld_clr", 32'(vld_v[0]), 32'h0);
    wait_clk(5);
    check_val("ov_xfer1", 32'(n_xfer[0] - bx), 32'd1);
    check_val("ov_last",  32'(last_d[0]),      32'h011);
    send_frame(0, 9'h033, 8, 0, 1'b0, 1, 1'b1);
    wait_clk(40);
    check_val("ov_33",    32'(last_d[0]),      32'h033);
    check_val("ov_xfer2", 32'(n_xfer[0] - bx), 32'd2);

    // Reset in the DATA state of 0xFF.
    bx = n_xfer[0];
    fork
      send_frame(0, 9'h0FF, 8, 0, 1'b0, 1, 1'b1);
      begin
        wait_clk(64 * 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("mr_d",    32'(d0),        32'h0);
        check_val("mr_vld",  32'(vld_v[0]),  32'h0);
        check_val("mr_busy", 32'(busy_v[0]), 32'h0);
        check_val("mr_frm",  32'(frm_v[0]),  32'h0);
        @(negedge clk);
        rst = 1'b0;
      end
    join
    wait_clk(100);
    check_val("mr_noxfer", 32'(n_xfer[0] - bx), 32'd0);
    send_frame(0, 9'h07E, 8, 0, 1'b0, 1, 1'b1);
    wait_clk(40);
    check_val("mr_7e",   32'(last_d[0]),      32'h07E);
    check_val("mr_xfer", 32'(n_xfer[0] - bx), 32'd1);

    // Parameter sweep: 5-bit and 9-bit odd parity, two stop bits.
    bx2 = n_xfer[2];
    bx3 = n_xfer[3];
    for (int k = 0; k < 4; k++) begin
      rd = 9'($urandom_range(0, 31));
      send_frame(2, rd, 5, 1, 1'b0, 2, 1'b1);
      wait_clk(40);
      check_val("sw5_d",   32'(last_d[2]),   32'(rd));
      check_val("sw5_err", 32'({last_frm[2], last_par[2]}), 32'h0);
      rd = 9'($urandom_range(0, 511));
      send_frame(3, rd, 9, 1, 1'b0, 2, 1'b1);
      wait_clk(40);
      check_val("sw9_d",   32'(last_d[3]),   32'(rd));
      check_val("sw9_err", 32'({last_frm[3], last_par[3]}), 32'h0);
    end
    check_val("sw5_xfer", 32'(n_xfer[2] - bx2), 32'd4);
    check_val("sw9_xfer", 32'(n_xfer[3] - bx3), 32'd4);
    send_frame(3, 9'h155, 9, 1, 1'b1, 2, 1'b1);
    wait_clk(40);
    check_val("sw9_bad_d",   32'(last_d[3]),   32'h155);
    check_val("sw9_bad_par", 32'(last_par[3]), 32'h1);
    check_val("sw_ovr", 32'(n_ovr[2] + n_ovr[3]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
